channel_input_capture: RTL and testbench
========================================

CHANNEL_INPUT_CAPTURE -- requirements
Module: channel_input_capture

Interface
REQ-001 SHALL have parameters, one per line: DATA_W, 12, ADC sample width; DELAY_W, 16, receive-delay width; LEN_W, 13, record-length width; FIFO_DEPTH, 4, output FIFO entries (power of two).
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports are listed REQ-003 to REQ-017.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd  input  2  command: 00 hold, 01 buffer, 10 fire, 11 reset_module.
REQ-006 recvDelay  input  DELAY_W  clk cycles from fire to capture start.
REQ-007 recordLength  input  LEN_W  samples to capture after decimation.
REQ-008 decim  input  4  keep 1 of every (decim+1) valid ADC samples.
REQ-009 rxMask  input  1  channel enable; 0 means the channel captures nothing.
REQ-010 adcData  input  DATA_W  ADC sample.
REQ-011 adcValid  input  1  adcData qualifier, one sample per asserted cycle.
REQ-012 outData  output  DATA_W  FIFO head sample.
REQ-013 outValid  output  1  FIFO non-empty.
REQ-014 outReady  input  1  consumer accepts outData when outValid&outReady.
REQ-015 isActive  output  1  high in DELAY and CAPTURE.
REQ-016 captureDone  output  1  one-cycle pulse on entry to DONE.
REQ-017 overflow  output  1  sticky; a kept sample was dropped because the FIFO was full.

Function
REQ-018 SHALL implement the states IDLE, LOADED, DELAY, CAPTURE and DONE.
REQ-019 cmd=01 in IDLE, LOADED or DONE SHALL latch recvDelay, recordLength, decim and rxMask, clear overflow, and enter LOADED; it SHALL be ignored in DELAY and CAPTURE.
REQ-020 cmd=10 SHALL act only in LOADED; it SHALL be ignored in all other states, so holding cmd=10 for many cycles fires exactly once.
REQ-021 Fire with latched length=0 or rxMask=0 SHALL go LOADED->DONE, pulse captureDone the next cycle, and never assert isActive.
REQ-022 Otherwise fire SHALL go to DELAY, with isActive=1 from the next cycle.
REQ-023 DELAY SHALL decrement the delay counter once per clk and enter CAPTURE on the cycle it reads 0; delay=D gives exactly D DELAY cycles (D=0 means zero).
REQ-024 In CAPTURE, each adcValid cycle with decimation counter 0 SHALL push adcData, reload the counter with decim, and decrement the length counter; adcValid with a nonzero counter SHALL only decrement the counter. The counter SHALL be 0 on CAPTURE entry.
REQ-025 The push that takes the length counter to 0 SHALL enter DONE: isActive=0 and captureDone=1 the next cycle.
REQ-026 A push into a full FIFO with no simultaneous pop SHALL drop the sample, set overflow, and still decrement the length counter.
REQ-027 A simultaneous push and pop on a full FIFO SHALL both succeed with no overflow.
REQ-028 Latency: a sample pushed at cycle n into an empty FIFO SHALL appear on outData with outValid=1 at n+1.
REQ-029 A pop SHALL occur only when outValid&outReady; outData SHALL hold while outValid&!outReady.
REQ-030 The FIFO SHALL keep draining in every state except under cmd=11/reset; cmd=01 SHALL NOT flush it.
REQ-031 cmd=11 in any state SHALL enter IDLE, zero all counters, flush the FIFO, and clear every output the next cycle.
REQ-032 cmd=00 SHALL hold state except for normal DELAY/CAPTURE/FIFO progress.

Reset
REQ-033 reset SHALL take priority over cmd, giving state IDLE, FIFO empty, and outData=0, outValid=0, isActive=0, captureDone=0, overflow=0.
REQ-034 reset mid-DELAY or mid-CAPTURE SHALL abort without a captureDone pulse.

Structure
REQ-035 Package rx_capture_pkg SHALL hold the cmd encodings (CMD_BUFFER=01, CMD_FIRE=10, CMD_RESET=11), the state enum and the default widths.
REQ-036 The FIFO SHALL be a separate sub-module, rx_sample_fifo (synchronous, flush input, full/empty flags).

Verification
REQ-037 delay=5, len=3, decim=0, rxMask=1, adcValid constant, data 1,2,3..., outReady=1 -> isActive for 5 DELAY + 3 CAPTURE cycles; outData 6,7,8; captureDone once.
REQ-038 decim=2, len=2, delay=0, data 10..20 -> outputs 10 and 13; captureDone after the 13 push.
REQ-039 outReady=0, len=6, delay=0 -> first 4 samples kept, overflow=1; raise outReady -> 4 samples drained, overflow stays 1 until the next cmd=01.
REQ-040 len=0, or rxMask=0 -> captureDone 1 cycle after fire, isActive never 1, no outValid.
REQ-041 cmd=10 held 20 cycles after DONE -> no re-fire; cmd=11 mid-CAPTURE -> IDLE, outValid=0 next cycle, no captureDone.
REQ-042 reset asserted together with cmd=01 -> state IDLE, all outputs 0.

Source files
------------

// File: rtl/rx_capture_pkg.sv
// Shared encodings and default widths for the receive-channel capture block.
package rx_capture_pkg;

   localparam int DEF_DATA_W     = 12;
   localparam int DEF_DELAY_W    = 16;
   localparam int DEF_LEN_W      = 13;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DECIM_W        = 4;

   typedef enum logic [1:0] {
      CMD_HOLD   = 2'b00,
      CMD_BUFFER = 2'b01,
      CMD_FIRE   = 2'b10,
      CMD_RESET  = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOADED  = 3'd1,
      ST_DELAY   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/rx_sample_fifo.sv
// Small synchronous FIFO with flush; head is presented combinationally and reads 0 when empty.
module rx_sample_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop_ok);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // NOTE: storage is deliberately not reset; the pointers define validity and head is masked when empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/channel_input_capture.sv
// One receive channel: arm, fire, wait a programmed delay, then capture decimated ADC samples into a FIFO.
module channel_input_capture
   import rx_capture_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DELAY_W    = DEF_DELAY_W,
   parameter int LEN_W      = DEF_LEN_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         cmd,
   input  logic [DELAY_W-1:0] recvDelay,
   input  logic [LEN_W-1:0]   recordLength,
   input  logic [DECIM_W-1:0] decim,
   input  logic               rxMask,
   input  logic [DATA_W-1:0]  adcData,
   input  logic               adcValid,
   output logic [DATA_W-1:0]  outData,
   output logic               outValid,
   input  logic               outReady,
   output logic               isActive,
   output logic               captureDone,
   output logic               overflow
);

   cmd_e               cmd_in;
   state_e             state;
   state_e             state_next;
   logic [DELAY_W-1:0] delay_q;
   logic [DELAY_W-1:0] delay_cnt;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   len_cnt;
   logic [DECIM_W-1:0] decim_q;
   logic [DECIM_W-1:0] dec_cnt;
   logic               mask_q;
   logic               buffer_go;
   logic               fire_go;
   logic               push_req;
   logic               pop;
   logic               flush;
   logic               fifo_full;
   logic               fifo_empty;
   logic               overflow_q;
   logic               capture_done_q;

   assign cmd_in = cmd_e'(cmd);
   assign flush  = (cmd_in == CMD_RESET);

   // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_next = state;
      buffer_go  = 1'b0;
      fire_go    = 1'b0;
      push_req   = 1'b0;
      if (cmd_in == CMD_RESET) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_LOADED, ST_DONE: begin
               if (cmd_in == CMD_BUFFER) begin
                  buffer_go  = 1'b1;
                  state_next = ST_LOADED;
               end else if (state == ST_LOADED && cmd_in == CMD_FIRE) begin
                  fire_go = 1'b1;
                  if (len_q == '0 || !mask_q) state_next = ST_DONE;
                  else if (delay_q == '0)     state_next = ST_CAPTURE;
                  else                        state_next = ST_DELAY;
               end
            end
            ST_DELAY: begin
               if (delay_cnt == '0) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (adcValid && dec_cnt == '0) begin
                  push_req = 1'b1;
                  if (len_cnt == LEN_W'(1)) state_next = ST_DONE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset || cmd_in == CMD_RESET) begin
         delay_q        <= '0;
         len_q          <= '0;
         decim_q        <= '0;
         mask_q         <= 1'b0;
         delay_cnt      <= '0;
         len_cnt        <= '0;
         dec_cnt        <= '0;
         overflow_q     <= 1'b0;
         capture_done_q <= 1'b0;
      end else begin
         capture_done_q <= (state_next == ST_DONE) && (state != ST_DONE);
         if (buffer_go) begin
            delay_q    <= recvDelay;
            len_q      <= recordLength;
            decim_q    <= decim;
            mask_q     <= rxMask;
            overflow_q <= 1'b0;
         end
         if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
         // Loading delay-1 makes the DELAY state last exactly the programmed number of cycles.
         if (fire_go) begin
            delay_cnt <= (delay_q == '0) ? '0 : delay_q - DELAY_W'(1);
            len_cnt   <= len_q;
            dec_cnt   <= '0;
         end
         if (state == ST_DELAY && delay_cnt != '0) delay_cnt <= delay_cnt - DELAY_W'(1);
         if (state == ST_CAPTURE && adcValid) begin
            if (dec_cnt == '0) begin
               dec_cnt <= decim_q;
               len_cnt <= len_cnt - LEN_W'(1);
            end else begin
               dec_cnt <= dec_cnt - DECIM_W'(1);
            end
         end
      end
   end

   rx_sample_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (push_req),
      .push_data (adcData),
      .pop       (pop),
      .head      (outData),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign outValid    = !fifo_empty;
   assign pop         = outValid && outReady;
   assign isActive    = (state == ST_DELAY) || (state == ST_CAPTURE);
   assign captureDone = capture_done_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_channel_input_capture.sv
// Scenario bench for channel_input_capture; expected samples are queued when stimulus is planned.
module tb_channel_input_capture;

   localparam int DATA_W     = 12;
   localparam int DELAY_W    = 16;
   localparam int LEN_W      = 13;
   localparam int FIFO_DEPTH = 4;

   localparam logic [1:0] C_HOLD = 2'b00;
   localparam logic [1:0] C_BUF  = 2'b01;
   localparam logic [1:0] C_FIRE = 2'b10;
   localparam logic [1:0] C_RST  = 2'b11;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         cmd;
   logic [DELAY_W-1:0] recvDelay;
   logic [LEN_W-1:0]   recordLength;
   logic [3:0]         decim;
   logic               rxMask;
   logic [DATA_W-1:0]  adcData;
   logic               adcValid;
   logic [DATA_W-1:0]  outData;
   logic               outValid;
   logic               outReady;
   logic               isActive;
   logic               captureDone;
   logic               overflow;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] sb_q[$];

   always #5 clk = ~clk;

   channel_input_capture #(
      .DATA_W     (DATA_W),
      .DELAY_W    (DELAY_W),
      .LEN_W      (LEN_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd          (cmd),
      .recvDelay    (recvDelay),
      .recordLength (recordLength),
      .decim        (decim),
      .rxMask       (rxMask),
      .adcData      (adcData),
      .adcValid     (adcValid),
      .outData      (outData),
      .outValid     (outValid),
      .outReady     (outReady),
      .isActive     (isActive),
      .captureDone  (captureDone),
      .overflow     (overflow)
   );

   // Drives cmd=01 with the given settings for one cycle, then leaves cmd=10 driven for the next edge.
   task automatic arm_and_fire(input int d, input int l, input int dc, input logic m);
      @(negedge clk);
      cmd          = C_BUF;
      recvDelay    = DELAY_W'(d);
      recordLength = LEN_W'(l);
      decim        = 4'(dc);
      rxMask       = m;
      @(negedge clk);
      cmd = C_FIRE;
   endtask

   task automatic test_reset();
      int active_seen = 0;
      int valid_seen  = 0;
      reset = 1'b1; cmd = C_BUF; recvDelay = '0; recordLength = LEN_W'(3);
      decim = '0; rxMask = 1'b1; adcValid = 1'b1; adcData = DATA_W'(12'h5A5); outReady = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (outData !== '0)      begin errors++; $display("FAIL reset_outData: got %0d expected 0", outData); end
      checks++; if (outValid !== 1'b0)   begin errors++; $display("FAIL reset_outValid: got %b expected 0", outValid); end
      checks++; if (isActive !== 1'b0)   begin errors++; $display("FAIL reset_isActive: got %b expected 0", isActive); end
      checks++; if (captureDone !== 1'b0) begin errors++; $display("FAIL reset_captureDone: got %b expected 0", captureDone); end
      checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      // A buffer command overridden by reset must leave nothing armed, so a fire does nothing.
      reset = 1'b0; cmd = C_FIRE;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         cmd = C_HOLD;
         if (isActive) active_seen++;
         if (outValid) valid_seen++;
      end
      adcValid = 1'b0;
      checks++; if (active_seen != 0) begin errors++; $display("FAIL reset_not_armed: isActive cycles %0d expected 0", active_seen); end
      checks++; if (valid_seen != 0)  begin errors++; $display("FAIL reset_no_output: outValid cycles %0d expected 0", valid_seen); end
   endtask

   task automatic test_basic();
      int active_cnt = 0, done_cnt = 0, done_k = 0, first_active_k = 0, first_valid_k = 0;
      logic [DATA_W-1:0] exp_d;
      sb_q.push_back(DATA_W'(6)); sb_q.push_back(DATA_W'(7)); sb_q.push_back(DATA_W'(8));
      outReady = 1'b1;
      arm_and_fire(5, 3, 0, 1'b1);
      adcValid = 1'b1; adcData = '0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         cmd = C_HOLD; adcData = DATA_W'(k);
         if (isActive) begin active_cnt++; if (first_active_k == 0) first_active_k = k; end
         if (captureDone) begin done_cnt++; done_k = k; end
         if (outValid && first_valid_k == 0) first_valid_k = k;
         if (outValid && outReady) begin
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL basic_extra: got outData=%0d expected no output", outData); end
            else begin
               exp_d = sb_q.pop_front();
               if (outData !== exp_d) begin errors++; $display("FAIL basic_data: got %0d expected %0d", outData, exp_d); end
            end
         end
      end
      adcValid = 1'b0;
      checks++; if (first_active_k != 1) begin errors++; $display("FAIL basic_active_start: got cycle %0d expected 1", first_active_k); end
      checks++; if (active_cnt != 8)     begin errors++; $display("FAIL basic_active_len: got %0d expected 8", active_cnt); end
      checks++; if (done_cnt != 1)       begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
      checks++; if (done_k != 9)         begin errors++; $display("FAIL basic_done_cycle: got %0d expected 9", done_k); end
      checks++; if (first_valid_k != 7)  begin errors++; $display("FAIL basic_latency: got cycle %0d expected 7", first_valid_k); end
      checks++; if (sb_q.size() != 0)    begin errors++; $display("FAIL basic_missing: got %0d outstanding expected 0", sb_q.size()); end
      sb_q.delete();
   endtask

   task automatic test_decim();
      int active_cnt = 0, done_cnt = 0, done_k = 0;
      logic [DATA_W-1:0] exp_d;
      sb_q.push_back(DATA_W'(10)); sb_q.push_back(DATA_W'(13));
      outReady = 1'b1;
      arm_and_fire(0, 2, 2, 1'b1);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         cmd = C_HOLD; adcData = DATA_W'(9 + k); adcValid = (k <= 11);
         if (isActive) active_cnt++;
         if (captureDone) begin done_cnt++; done_k = k; end
         if (outValid && outReady) begin
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL decim_extra: got outData=%0d expected no output", outData); end
            else begin
               exp_d = sb_q.pop_front();
               if (outData !== exp_d) begin errors++; $display("FAIL decim_data: got %0d expected %0d", outData, exp_d); end
            end
         end
      end
      adcValid = 1'b0;
      checks++; if (active_cnt != 4)  begin errors++; $display("FAIL decim_active_len: got %0d expected 4", active_cnt); end
      checks++; if (done_cnt != 1)    begin errors++; $display("FAIL decim_done_count: got %0d expected 1", done_cnt); end
      checks++; if (done_k != 5)      begin errors++; $display("FAIL decim_done_cycle: got %0d expected 5", done_k); end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL decim_missing: got %0d outstanding expected 0", sb_q.size()); end
      sb_q.delete();
   endtask

   task automatic test_overflow();
      int ovf_k = 0, drained = 0;
      logic [DATA_W-1:0] exp_d;
      for (int i = 101; i <= 104; i++) sb_q.push_back(DATA_W'(i));
      outReady = 1'b0;
      arm_and_fire(0, 6, 0, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         cmd = C_HOLD; adcData = DATA_W'(100 + k); adcValid = 1'b1;
         if (overflow && ovf_k == 0) ovf_k = k;
      end
      adcValid = 1'b0;
      checks++; if (ovf_k != 6)         begin errors++; $display("FAIL ovf_set_cycle: got %0d expected 6", ovf_k); end
      checks++; if (outValid !== 1'b1)  begin errors++; $display("FAIL ovf_valid_held: got %b expected 1", outValid); end
      checks++; if (outData !== DATA_W'(101)) begin errors++; $display("FAIL ovf_head_held: got %0d expected 101", outData); end
      // Drain with a buffer command in the middle: it clears overflow but must not flush queued samples.
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         outReady = 1'b1;
         cmd = (k == 3) ? C_BUF : C_HOLD;
         if (k == 3) begin recvDelay = '0; recordLength = LEN_W'(8); decim = '0; rxMask = 1'b1; end
         if (k == 2) begin checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end end
         if (k == 4) begin checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", overflow); end end
         if (outValid && outReady) begin
            drained++;
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL ovf_extra: got outData=%0d expected no output", outData); end
            else begin
               exp_d = sb_q.pop_front();
               if (outData !== exp_d) begin errors++; $display("FAIL ovf_data: got %0d expected %0d", outData, exp_d); end
            end
         end
      end
      cmd = C_HOLD;
      checks++; if (drained != 4) begin errors++; $display("FAIL ovf_drained: got %0d expected 4", drained); end
      sb_q.delete();
   endtask

   task automatic test_full_pushpop();
      int ovf_seen = 0, done_cnt = 0;
      logic [DATA_W-1:0] exp_d;
      for (int i = 201; i <= 208; i++) sb_q.push_back(DATA_W'(i));
      outReady = 1'b0;
      arm_and_fire(0, 8, 0, 1'b1);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         cmd = C_HOLD; adcData = DATA_W'(200 + k); adcValid = 1'b1; outReady = (k >= 5);
         if (overflow) ovf_seen++;
         if (captureDone) done_cnt++;
         if (outValid && outReady) begin
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL fpp_extra: got outData=%0d expected no output", outData); end
            else begin
               exp_d = sb_q.pop_front();
               if (outData !== exp_d) begin errors++; $display("FAIL fpp_data: got %0d expected %0d", outData, exp_d); end
            end
         end
      end
      adcValid = 1'b0;
      checks++; if (ovf_seen != 0)    begin errors++; $display("FAIL fpp_overflow: got %0d overflow cycles expected 0", ovf_seen); end
      checks++; if (done_cnt != 1)    begin errors++; $display("FAIL fpp_done_count: got %0d expected 1", done_cnt); end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL fpp_missing: got %0d outstanding expected 0", sb_q.size()); end
      sb_q.delete();
   endtask

   task automatic test_zero_capture();
      for (int cfg = 0; cfg < 2; cfg++) begin
         int active_cnt = 0, done_cnt = 0, done_k = 0, valid_cnt = 0;
         outReady = 1'b1;
         if (cfg == 0) arm_and_fire(3, 0, 0, 1'b1);
         else          arm_and_fire(3, 4, 0, 1'b0);
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            cmd = C_HOLD; adcValid = 1'b1; adcData = DATA_W'(k);
            if (isActive) active_cnt++;
            if (outValid) valid_cnt++;
            if (captureDone) begin done_cnt++; done_k = k; end
         end
         adcValid = 1'b0;
         checks++; if (done_k != 1)     begin errors++; $display("FAIL zero%0d_done_cycle: got %0d expected 1", cfg, done_k); end
         checks++; if (done_cnt != 1)   begin errors++; $display("FAIL zero%0d_done_count: got %0d expected 1", cfg, done_cnt); end
         checks++; if (active_cnt != 0) begin errors++; $display("FAIL zero%0d_active: got %0d expected 0", cfg, active_cnt); end
         checks++; if (valid_cnt != 0)  begin errors++; $display("FAIL zero%0d_valid: got %0d expected 0", cfg, valid_cnt); end
      end
   endtask

   task automatic test_refire();
      int active_cnt = 0, done_cnt = 0, valid_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         cmd = C_FIRE; adcValid = 1'b1; adcData = DATA_W'(k);
         if (isActive) active_cnt++;
         if (captureDone) done_cnt++;
         if (outValid) valid_cnt++;
      end
      cmd = C_HOLD; adcValid = 1'b0;
      checks++; if (active_cnt != 0) begin errors++; $display("FAIL refire_active: got %0d expected 0", active_cnt); end
      checks++; if (done_cnt != 0)   begin errors++; $display("FAIL refire_done: got %0d expected 0", done_cnt); end
      checks++; if (valid_cnt != 0)  begin errors++; $display("FAIL refire_valid: got %0d expected 0", valid_cnt); end
   endtask

   task automatic test_abort();
      int done_cnt = 0, active_cnt = 0;
      outReady = 1'b0;
      arm_and_fire(0, 8, 0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         cmd = (k == 4) ? C_RST : C_HOLD; adcValid = 1'b1; adcData = DATA_W'(50 + k);
         if (k == 4) begin
            checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid: got %b expected 1", outValid); end
            checks++; if (isActive !== 1'b1) begin errors++; $display("FAIL abort_pre_active: got %b expected 1", isActive); end
         end
      end
      @(negedge clk);
      cmd = C_HOLD;
      checks++; if (outValid !== 1'b0)    begin errors++; $display("FAIL abort_valid: got %b expected 0", outValid); end
      checks++; if (outData !== '0)       begin errors++; $display("FAIL abort_outData: got %0d expected 0", outData); end
      checks++; if (isActive !== 1'b0)    begin errors++; $display("FAIL abort_active: got %b expected 0", isActive); end
      checks++; if (captureDone !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", captureDone); end
      repeat (10) begin
         @(negedge clk);
         if (captureDone) done_cnt++;
         if (isActive) active_cnt++;
      end
      checks++; if (done_cnt != 0 || active_cnt != 0) begin
         errors++; $display("FAIL abort_quiet: got done=%0d active=%0d expected 0 0", done_cnt, active_cnt);
      end
      // Reset asserted part-way through the delay must abort silently.
      done_cnt = 0; active_cnt = 0;
      arm_and_fire(10, 3, 0, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         cmd = C_HOLD;
      end
      checks++; if (isActive !== 1'b1) begin errors++; $display("FAIL rst_delay_pre: got %b expected 1", isActive); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (15) begin
         if (captureDone) done_cnt++;
         if (isActive) active_cnt++;
         @(negedge clk);
      end
      adcValid = 1'b0;
      checks++; if (done_cnt != 0 || active_cnt != 0) begin
         errors++; $display("FAIL rst_delay_abort: got done=%0d active=%0d expected 0 0", done_cnt, active_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_decim();
      test_overflow();
      test_full_pushpop();
      test_zero_capture();
      test_refire();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
